// File: rtl/cdc_clear_seq_pkg.sv
// Shared types for the CDC clear sequencer: FSM state encoding and requester limit.
package cdc_clear_seq_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LAUNCH   = 4'd1,
        ST_WAIT_ISO = 4'd2,
        ST_DRAIN    = 4'd3,
        ST_ISO_ACK  = 4'd4,
        ST_CLEAR    = 4'd5,
        ST_CLR_ACK  = 4'd6,
        ST_WAIT_END = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

endpackage

// File: rtl/cdc_clear_seq_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter
    import cdc_clear_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_clear_seq.sv
// Local-domain clear sequencer for one CDC reset controller half.
// Define CDC_CLEAR_SEQ_TIMEOUT_EN to bound the drain phase with a timeout counter.
module cdc_clear_seq
    import cdc_clear_seq_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CLEAR_CYCLES  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               busy_o,
    output logic               ctrl_clear_o,
    input  logic               ctrl_isolate_i,
    input  logic               ctrl_clear_i,
    output logic               ctrl_isolate_ack_o,
    output logic               ctrl_clear_ack_o,
    input  logic               idle_i,
    output logic               local_isolate_o,
    output logic               local_clear_o,
    output logic               timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     winner_q, winner_d;
    logic                 local_flag_q;
    logic [CLR_W-1:0]     clr_cnt_q;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [MAX_REQ-1:0]   arb_gnt_ext;
    logic                 drain_tmo;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    assign arb_gnt_ext = MAX_REQ'(arb_gnt);

    always_comb begin
        winner_d = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (arb_gnt_ext[i]) winner_d = PTR_W'(i);
        end
    end

`ifdef CDC_CLEAR_SEQ_TIMEOUT_EN
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [DRN_W-1:0] drn_cnt_q;
    logic             timeout_q;

    // Counter holds at zero outside DRAIN and saturates instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (state_q != ST_DRAIN) begin
            drn_cnt_q <= '0;
        end else if (drn_cnt_q != DRN_W'(DRAIN_TIMEOUT)) begin
            drn_cnt_q <= drn_cnt_q + 1'b1;
        end
    end

    assign drain_tmo = (state_q == ST_DRAIN) && (drn_cnt_q == DRN_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (drain_tmo && !idle_i) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign drain_tmo = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_isolate_i)  state_d = ST_DRAIN;
                else if (|req_i)     state_d = ST_LAUNCH;
            end
            ST_LAUNCH:   state_d = ST_WAIT_ISO;
            ST_WAIT_ISO: if (ctrl_isolate_i) state_d = ST_DRAIN;
            ST_DRAIN:    if (idle_i || drain_tmo) state_d = ST_ISO_ACK;
            ST_ISO_ACK:  if (ctrl_clear_i) state_d = ST_CLEAR;
            ST_CLEAR:    if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = ST_CLR_ACK;
            ST_CLR_ACK:  if (!ctrl_clear_i) state_d = ST_WAIT_END;
            ST_WAIT_END: if (!ctrl_isolate_i) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            local_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (ctrl_isolate_i)  local_flag_q <= 1'b0;
                else if (|req_i)     local_flag_q <= 1'b1;
            end
            if (state_q == ST_DONE && local_flag_q) begin
                rr_ptr_q <= (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
            end
        end
    end

    // Winner and clear counter are qualified by state, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_IDLE && !ctrl_isolate_i && (|req_i)) begin
            winner_q <= winner_d;
        end
        if (state_q != ST_CLEAR) begin
            clr_cnt_q <= '0;
        end else if (clr_cnt_q != CLR_W'(CLEAR_CYCLES)) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    assign busy_o             = (state_q != ST_IDLE);
    assign ctrl_clear_o       = (state_q == ST_LAUNCH);
    assign local_clear_o      = (state_q == ST_CLEAR);
    assign ctrl_clear_ack_o   = (state_q == ST_CLR_ACK);
    assign ctrl_isolate_ack_o = (state_q == ST_ISO_ACK) || (state_q == ST_CLEAR) ||
                                (state_q == ST_CLR_ACK) || (state_q == ST_WAIT_END);
    assign local_isolate_o    = (state_q == ST_DRAIN) || ctrl_isolate_ack_o;
    assign gnt_o              = (state_q == ST_DONE && local_flag_q) ?
                                (NUM_REQ'(1) << winner_q) : '0;

endmodule

// File: tb/tb_cdc_clear_seq.sv
// Scoreboard bench for cdc_clear_seq with a behavioural controller and requester model.
module tb_cdc_clear_seq;

    localparam int NUM_REQ       = 4;
    localparam int DRAIN_TIMEOUT = 16;
    localparam int CLEAR_CYCLES  = 4;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic [NUM_REQ-1:0] req_i = '0;
    logic [NUM_REQ-1:0] gnt_o;
    logic               busy_o, ctrl_clear_o, ctrl_isolate_ack_o, ctrl_clear_ack_o;
    logic               ctrl_isolate_i = 1'b0;
    logic               ctrl_clear_i = 1'b0;
    logic               idle_i = 1'b0;
    logic               local_isolate_o, local_clear_o, timeout_o;

    cdc_clear_seq #(
        .NUM_REQ       (NUM_REQ),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .CLEAR_CYCLES  (CLEAR_CYCLES)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_i              (req_i),
        .gnt_o              (gnt_o),
        .busy_o             (busy_o),
        .ctrl_clear_o       (ctrl_clear_o),
        .ctrl_isolate_i     (ctrl_isolate_i),
        .ctrl_clear_i       (ctrl_clear_i),
        .ctrl_isolate_ack_o (ctrl_isolate_ack_o),
        .ctrl_clear_ack_o   (ctrl_clear_ack_o),
        .idle_i             (idle_i),
        .local_isolate_o    (local_isolate_o),
        .local_clear_o      (local_clear_o),
        .timeout_o          (timeout_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [NUM_REQ-1:0] exp_q[$];
    int m_ptr = 0;
    int exp_launch = 0;
    int n_launch = 0;

    // behavioural controller and stimulus state
    int c_phase = 0;
    int c_dly = 0;
    int idle_mode = 0;
    logic pend_v = 1'b0;
    logic pend_remote = 1'b0;
    logic [NUM_REQ-1:0] pend_mask = '0;

    function automatic void chk(string nm, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Requests present together are served in round-robin order from the pointer.
    function automatic void push_grants(logic [NUM_REQ-1:0] m);
        int last = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i = (m_ptr + k) % NUM_REQ;
            if (m[i]) begin
                exp_q.push_back(NUM_REQ'(1) << i);
                last = i;
            end
        end
        if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
        exp_launch += $countones(m);
    endfunction

    task automatic step();
        @(negedge clk);
        req_i = req_i & ~gnt_o;
        case (idle_mode)
            1:       idle_i = 1'b0;
            2:       idle_i = 1'b1;
            default: idle_i = ($urandom_range(0, 2) != 0);
        endcase
        case (c_phase)
            0: if (ctrl_clear_o === 1'b1) begin c_phase = 1; c_dly = $urandom_range(0, 3); end
            1: if (c_dly == 0) begin ctrl_isolate_i = 1'b1; c_phase = 2; end else c_dly--;
            2: if (ctrl_isolate_ack_o === 1'b1) begin c_phase = 3; c_dly = $urandom_range(0, 3); end
            3: if (c_dly == 0) begin ctrl_clear_i = 1'b1; c_phase = 4; end else c_dly--;
            4: if (ctrl_clear_ack_o === 1'b1) begin c_phase = 5; c_dly = $urandom_range(0, 3); end
            5: if (c_dly == 0) begin ctrl_clear_i = 1'b0; c_phase = 6; c_dly = $urandom_range(0, 3); end
               else c_dly--;
            6: if (c_dly == 0) begin ctrl_isolate_i = 1'b0; c_phase = 0; end else c_dly--;
            default: c_phase = 0;
        endcase
        if (pend_v) begin
            req_i = req_i | pend_mask;
            if (pend_remote) begin
                ctrl_isolate_i = 1'b1;
                c_phase        = 2;
            end
            pend_v = 1'b0;
        end
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(busy_o === 1'b0 && c_phase == 0 && req_i == '0) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) chk("quiet_timeout", n, 0);
    endtask

    task automatic run_ep(logic [NUM_REQ-1:0] mask, logic remote);
        wait_quiet();
        push_grants(mask);
        pend_mask   = mask;
        pend_remote = remote;
        pend_v      = 1'b1;
        step();
        step();
        chk("launch_lat", ctrl_clear_o, remote ? 0 : 1);
        wait_quiet();
        chk("grants_left", exp_q.size(), 0);
        chk("launch_cnt", n_launch, exp_launch);
    endtask

    // Monitor: grants against the scoreboard, pulse widths and the IDLE gap.
    initial begin
        logic [NUM_REQ-1:0] e;
        logic prev_gnt = 1'b0;
        logic prev_launch = 1'b0;
        int   clr_run = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                clr_run     = 0;
                prev_gnt    = 1'b0;
                prev_launch = 1'b0;
            end else begin
                if (prev_gnt) chk("idle_gap", busy_o, 0);
                if (gnt_o != '0) begin
                    if (exp_q.size() == 0) chk("gnt_unexpected", gnt_o, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("gnt", gnt_o, e);
                    end
                end
                prev_gnt = (gnt_o != '0);
                if (ctrl_clear_o) begin
                    n_launch++;
                    chk("launch_pulse", prev_launch, 0);
                end
                prev_launch = ctrl_clear_o;
                if (local_clear_o) clr_run++;
                else if (clr_run != 0) begin
                    chk("clr_len", clr_run, CLEAR_CYCLES);
                    clr_run = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        repeat (3) step();
        chk("rst_outs", {gnt_o, busy_o, ctrl_clear_o, ctrl_isolate_ack_o, ctrl_clear_ack_o,
                         local_isolate_o, local_clear_o, timeout_o}, 0);
        rst_i = 1'b0;
        step();

        run_ep(4'b1111, 1'b0);
        run_ep(4'b0100, 1'b0);
        run_ep(4'b0001, 1'b1);
        for (int t = 0; t < 40; t++) begin
            logic rem;
            rem = ($urandom_range(0, 3) == 0);
            run_ep(NUM_REQ'($urandom_range(rem ? 0 : 1, 15)), rem);
        end

        // drain behaviour with idle_i held low
        wait_quiet();
        idle_mode = 1;
        push_grants(4'b0010);
        pend_mask = 4'b0010; pend_remote = 1'b0; pend_v = 1'b1;
        n = 0;
        do begin step(); n++; end while (local_isolate_o !== 1'b1 && n < 200);
        chk("drain_entry", local_isolate_o, 1);
`ifdef CDC_CLEAR_SEQ_TIMEOUT_EN
        cnt = 0;
        while (ctrl_isolate_ack_o !== 1'b1 && cnt < 100) begin step(); cnt++; end
        chk("drain_timeout_cycles", cnt, DRAIN_TIMEOUT);
        chk("timeout_set", timeout_o, 1);
        idle_mode = 0;
        wait_quiet();
        chk("timeout_sticky", timeout_o, 1);
`else
        cnt = 0;
        repeat (5000) begin step(); cnt++; end
        chk("drain_hold_ack", ctrl_isolate_ack_o, 0);
        chk("drain_hold_iso", local_isolate_o, 1);
        chk("drain_no_timeout", timeout_o, 0);
        idle_mode = 2;
        step();
        step();
        chk("drain_idle_ack", ctrl_isolate_ack_o, 1);
        idle_mode = 0;
        wait_quiet();
        chk("timeout_still_0", timeout_o, 0);
`endif
        chk("drain_grants_left", exp_q.size(), 0);

        // reset on the second local_clear_o cycle
        wait_quiet();
        idle_mode = 2;
        exp_launch += 1;
        pend_mask = 4'b0100; pend_remote = 1'b0; pend_v = 1'b1;
        n = 0; cnt = 0;
        while (cnt < 2 && n < 500) begin
            step();
            n++;
            if (local_clear_o === 1'b1) cnt++;
        end
        chk("clr_seen_twice", cnt, 2);
        rst_i = 1'b1;
        c_phase = 0; ctrl_isolate_i = 1'b0; ctrl_clear_i = 1'b0; req_i = '0;
        step();
        chk("midrst_outs", {gnt_o, busy_o, ctrl_clear_o, ctrl_isolate_ack_o, ctrl_clear_ack_o,
                            local_isolate_o, local_clear_o}, 0);
        chk("midrst_timeout", timeout_o, 0);
        exp_q.delete();
        m_ptr = 0;
        step();
        rst_i = 1'b0;
        idle_mode = 0;
        step();
        run_ep(4'b1010, 1'b0);
        run_ep(4'b0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
